// File: rtl/pwm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ctrl_if
// Purpose  : Host register bus between the system host and pwm_ctrl.
//            The host holds host_req (with we/addr/wdata) until host_ack.
// Ports    : host_req, host_we, host_addr[3:0], host_wdata[15:0]  (host -> ctrl)
//            host_rdata[15:0], host_ack                           (ctrl -> host)
// Revision : 1.0  initial release
// ============================================================================
interface pwm_ctrl_if;
    logic        host_req;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;
    logic        host_ack;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack
    );
endinterface
`default_nettype wire

// File: rtl/pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ctrl
// Purpose  : PWM bank controller. Generates the shared 15-bit timebase
//            (programmable period + prescaler, shadowed period update) and
//            turns host bus accesses into per-channel cs/rd/data sequences.
// Ports    : sys_clk, rst (async, active-high)
//            host       - pwm_ctrl_if.slave host register bus
//            counter    - shared PWM timebase
//            tb_wrap    - one-cycle pulse when counter returns to 0
//            ch_cs      - one-hot channel select
//            ch_rd      - 1 = channel read, 0 = channel write
//            ch_data_o  - channel bus write data, ch_data_oe its enable
//            ch_data_i  - channel bus read-back data
// Revision : 1.0  initial release
// ============================================================================
module pwm_ctrl #(
    parameter int NCH     = 4,
    parameter int ACC_CYC = 3
) (
    input  wire              sys_clk,
    input  wire              rst,
    pwm_ctrl_if.slave        host,
    output logic [14:0]      counter,
    output logic             tb_wrap,
    output logic [NCH-1:0]   ch_cs,
    output logic             ch_rd,
    output logic [15:0]      ch_data_o,
    output logic             ch_data_oe,
    input  wire  [15:0]      ch_data_i
);
    localparam int            C_CW   = $clog2(ACC_CYC) + 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(ACC_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REG_ACK = 3'd1,
        CH_ACC  = 3'd2,
        CH_GAP  = 3'd3,
        CH_ACK  = 3'd4
    } state_t;

    state_t          r_state, w_state_nx;
    logic [C_CW-1:0] r_acc_cnt, w_acc_cnt_nx;
    logic [2:0]      r_chan;
    logic            r_we;
    logic [15:0]     r_wdata;
    logic [15:0]     r_cap;

    logic            r_run, r_pending;
    logic [14:0]     r_shadow, r_active;
    logic [7:0]      r_presc, r_pcnt;

    logic            w_idle_req, w_is_ch, w_reg_start;
    logic            w_wr_ctrl, w_wr_period, w_wr_presc, w_clr, w_tick;
    logic [15:0]     w_reg_rdata;

    logic [2:0]      w_chan;
    logic            w_we;
    logic [15:0]     w_wdata;
    logic [NCH-1:0]  w_cs_nx;
    logic            w_rd_nx, w_oe_nx, w_ack_nx;
    logic [15:0]     w_do_nx, w_rdata_nx;

    // ---------------- request decode (IDLE only) ----------------
    assign w_idle_req  = (r_state == IDLE) && host.host_req;
    assign w_is_ch     = host.host_addr[3] && (int'(host.host_addr[2:0]) < NCH);
    assign w_reg_start = w_idle_req && !w_is_ch;
    assign w_wr_ctrl   = w_reg_start && host.host_we && (host.host_addr == 4'd0);
    assign w_wr_period = w_reg_start && host.host_we && (host.host_addr == 4'd1);
    assign w_wr_presc  = w_reg_start && host.host_we && (host.host_addr == 4'd2);
    assign w_clr       = w_wr_ctrl && host.host_wdata[1];
    assign w_tick      = r_run && (r_pcnt == r_presc);

    always_comb begin
        w_reg_rdata = 16'd0;
        case (host.host_addr)
            4'd0:    w_reg_rdata = {15'd0, r_run};
            4'd1:    w_reg_rdata = {1'b0, r_shadow};
            4'd2:    w_reg_rdata = {8'd0, r_presc};
            4'd3:    w_reg_rdata = {14'd0, r_pending, r_run};
            default: w_reg_rdata = 16'd0;
        endcase
    end

    // ---------------- access FSM: next state + next registered outputs ----------------
    // Outputs are registered from the next state, so in the IDLE cycle the live
    // request fields are used; afterwards the latched copies.
    always_comb begin
        w_state_nx   = r_state;
        w_acc_cnt_nx = r_acc_cnt;
        w_chan       = (r_state == IDLE) ? host.host_addr[2:0] : r_chan;
        w_we         = (r_state == IDLE) ? host.host_we        : r_we;
        w_wdata      = (r_state == IDLE) ? host.host_wdata     : r_wdata;
        w_cs_nx      = '0;
        w_rdata_nx   = 16'd0;

        unique case (r_state)
            IDLE: begin
                w_acc_cnt_nx = '0;
                if (host.host_req)
                    w_state_nx = w_is_ch ? CH_ACC : REG_ACK;
            end
            REG_ACK: w_state_nx = IDLE;
            CH_ACC: begin
                if (r_acc_cnt == C_LAST)
                    w_state_nx = CH_GAP;
                else
                    w_acc_cnt_nx = r_acc_cnt + C_CW'(1);
            end
            CH_GAP:  w_state_nx = CH_ACK;
            CH_ACK:  w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase

        for (int k = 0; k < NCH; k++)
            w_cs_nx[k] = (w_state_nx == CH_ACC) && (int'(w_chan) == k);
        w_rd_nx  = (w_state_nx == CH_ACC) && !w_we;
        w_oe_nx  = (w_state_nx == CH_ACC) && w_we;
        w_do_nx  = w_oe_nx ? w_wdata : 16'd0;
        w_ack_nx = (w_state_nx == REG_ACK) || (w_state_nx == CH_ACK);
        if (w_state_nx == REG_ACK && !w_we)
            w_rdata_nx = w_reg_rdata;
        else if (w_state_nx == CH_ACK && !r_we)
            w_rdata_nx = r_cap;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_acc_cnt       <= '0;
            r_chan          <= 3'd0;
            r_we            <= 1'b0;
            r_wdata         <= 16'd0;
            r_cap           <= 16'd0;
            ch_cs           <= '0;
            ch_rd           <= 1'b0;
            ch_data_o       <= 16'd0;
            ch_data_oe      <= 1'b0;
            host.host_ack   <= 1'b0;
            host.host_rdata <= 16'd0;
        end else begin
            r_state   <= w_state_nx;
            r_acc_cnt <= w_acc_cnt_nx;
            if (w_idle_req) begin
                r_chan  <= host.host_addr[2:0];
                r_we    <= host.host_we;
                r_wdata <= host.host_wdata;
            end
            // Sample the channel on the last select cycle, before cs drops.
            if (r_state == CH_ACC && r_acc_cnt == C_LAST && !r_we)
                r_cap <= ch_data_i;
            ch_cs           <= w_cs_nx;
            ch_rd           <= w_rd_nx;
            ch_data_o       <= w_do_nx;
            ch_data_oe      <= w_oe_nx;
            host.host_ack   <= w_ack_nx;
            host.host_rdata <= w_rdata_nx;
        end
    end

    // ---------------- timebase and register file ----------------
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_run     <= 1'b0;
            r_pending <= 1'b0;
            r_shadow  <= 15'h7FFF;
            r_active  <= 15'h7FFF;
            r_presc   <= 8'd0;
            r_pcnt    <= 8'd0;
            counter   <= 15'd0;
            tb_wrap   <= 1'b0;
        end else begin
            tb_wrap <= 1'b0;
            if (w_clr) begin
                // clr overrides any tick in the same cycle and never pulses tb_wrap
                counter   <= 15'd0;
                r_pcnt    <= 8'd0;
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (w_tick) begin
                r_pcnt <= 8'd0;
                if (counter == r_active) begin
                    counter <= 15'd0;
                    tb_wrap <= 1'b1;
                    if (r_pending) begin
                        r_active  <= r_shadow;
                        r_pending <= 1'b0;
                    end
                end else begin
                    counter <= counter + 15'd1;
                end
            end else if (r_run) begin
                r_pcnt <= r_pcnt + 8'd1;
            end

            // Placed after the wrap logic so a write landing on a wrap edge
            // stays pending for the following wrap.
            if (w_wr_period) begin
                r_shadow <= host.host_wdata[14:0];
                if (r_run) begin
                    r_pending <= 1'b1;
                end else begin
                    r_active  <= host.host_wdata[14:0];
                    r_pending <= 1'b0;
                end
            end
            if (w_wr_ctrl)
                r_run <= host.host_wdata[0];
            if (w_wr_presc)
                r_presc <= host.host_wdata[7:0];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ctrl
// Purpose  : Directed self-checking bench for pwm_ctrl with expected-value
//            queues for host read data and the timebase sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_ctrl;
    localparam int NCH = 4;
    localparam int ACC = 3;

    logic           sys_clk = 1'b0;
    logic           rst     = 1'b1;
    logic [14:0]    counter;
    logic           tb_wrap;
    logic [NCH-1:0] ch_cs;
    logic           ch_rd;
    logic [15:0]    ch_data_o;
    logic           ch_data_oe;
    logic [15:0]    ch_data_i;

    int total = 0;
    int bad   = 0;

    logic [15:0] rd_q[$];
    logic [14:0] cnt_q[$];
    logic        wrap_q[$];

    logic [14:0] a_cnt;
    logic        a_wrap;
    int          n;

    pwm_ctrl_if hif();

    pwm_ctrl #(.NCH(NCH), .ACC_CYC(ACC)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .host       (hif),
        .counter    (counter),
        .tb_wrap    (tb_wrap),
        .ch_cs      (ch_cs),
        .ch_rd      (ch_rd),
        .ch_data_o  (ch_data_o),
        .ch_data_oe (ch_data_oe),
        .ch_data_i  (ch_data_i)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Register access; called just after a falling edge, returns one cycle after ack.
    task automatic reg_access(input logic we, input logic [3:0] addr, input logic [15:0] wd,
                              input logic [15:0] exp_rd,
                              output logic [14:0] ack_cnt, output logic ack_wrap);
        int          lat;
        logic [15:0] e;
        if (!we) rd_q.push_back(exp_rd);
        hif.host_req   = 1'b1;
        hif.host_we    = we;
        hif.host_addr  = addr;
        hif.host_wdata = wd;
        lat = 0;
        do begin
            @(negedge sys_clk);
            lat++;
        end while (hif.host_ack !== 1'b1 && lat < 20);
        ack_cnt  = counter;
        ack_wrap = tb_wrap;
        chk($sformatf("reg_ack_latency a%0d", addr), lat, 1);
        if (!we) begin
            e = rd_q.pop_front();
            chk($sformatf("reg_rdata a%0d", addr), hif.host_rdata, e);
        end
        hif.host_req = 1'b0;
        @(negedge sys_clk);
        chk("ack_single_pulse", hif.host_ack, 1'b0);
    endtask

    // Channel access with a cycle-by-cycle check of the channel bus.
    task automatic ch_access(input logic we, input logic [2:0] k, input logic [15:0] wd,
                             input logic [15:0] din);
        logic [NCH-1:0] oh;
        logic           act;
        logic [15:0]    e;
        oh = NCH'(1) << k;
        rd_q.push_back(we ? 16'h0000 : din);
        ch_data_i      = din;
        hif.host_req   = 1'b1;
        hif.host_we    = we;
        hif.host_addr  = {1'b1, k};
        hif.host_wdata = wd;
        for (int c = 1; c <= ACC + 2; c++) begin
            @(negedge sys_clk);
            act = (c <= ACC);
            chk($sformatf("ch_cs c%0d", c),      ch_cs,      act ? oh : '0);
            chk($sformatf("ch_rd c%0d", c),      ch_rd,      act & ~we);
            chk($sformatf("ch_oe c%0d", c),      ch_data_oe, act & we);
            chk($sformatf("ch_do c%0d", c),      ch_data_o,  (act && we) ? wd : 16'h0);
            chk($sformatf("ch_ack c%0d", c),     hif.host_ack, (c == ACC + 2));
            if (c == ACC + 2) begin
                e = rd_q.pop_front();
                chk("ch_rdata", hif.host_rdata, e);
            end
        end
        hif.host_req = 1'b0;
        @(negedge sys_clk);
        chk("ch_ack_single_pulse", hif.host_ack, 1'b0);
    endtask

    // Compare queued counter/tb_wrap expectations, one per cycle.
    task automatic run_seq(input string tag);
        logic [14:0] ec;
        logic        ew;
        int          i;
        i = 0;
        while (cnt_q.size() > 0) begin
            ec = cnt_q.pop_front();
            ew = wrap_q.pop_front();
            chk($sformatf("%s_cnt i%0d", tag, i),  counter, ec);
            chk($sformatf("%s_wrap i%0d", tag, i), tb_wrap, ew);
            i++;
            @(negedge sys_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        hif.host_req   = 1'b0;
        hif.host_we    = 1'b0;
        hif.host_addr  = 4'd0;
        hif.host_wdata = 16'd0;
        ch_data_i      = 16'd0;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);

        // Reset values
        chk("rst_counter", counter, 0);
        chk("rst_wrap",    tb_wrap, 0);
        chk("rst_ack",     hif.host_ack, 0);
        chk("rst_cs",      ch_cs, 0);
        chk("rst_oe",      ch_data_oe, 0);
        reg_access(1'b0, 4'd1, 16'h0, 16'h7FFF, a_cnt, a_wrap);
        reg_access(1'b0, 4'd2, 16'h0, 16'h0000, a_cnt, a_wrap);
        reg_access(1'b0, 4'd3, 16'h0, 16'h0000, a_cnt, a_wrap);
        reg_access(1'b0, 4'd0, 16'h0, 16'h0000, a_cnt, a_wrap);

        // Timebase: PERIOD=4, PRESC=1 -> 0,0,1,1,..,4,4,0 with a wrap every 10 cycles
        reg_access(1'b1, 4'd1, 16'd4, 16'h0, a_cnt, a_wrap);
        reg_access(1'b1, 4'd2, 16'd1, 16'h0, a_cnt, a_wrap);
        reg_access(1'b0, 4'd1, 16'h0, 16'd4, a_cnt, a_wrap);
        reg_access(1'b1, 4'd0, 16'd1, 16'h0, a_cnt, a_wrap);
        chk("run_ack_cnt", a_cnt, 0);
        for (int c = 2; c <= 31; c++) begin
            cnt_q.push_back(15'(((c - 1) / 2) % 5));
            wrap_q.push_back(((c - 1) % 10) == 0);
        end
        run_seq("tbase");

        // Shadow period update
        reg_access(1'b1, 4'd0, 16'd2, 16'h0, a_cnt, a_wrap);
        chk("clr_stop_cnt", a_cnt, 0);
        reg_access(1'b1, 4'd2, 16'd0, 16'h0, a_cnt, a_wrap);
        reg_access(1'b1, 4'd1, 16'd9, 16'h0, a_cnt, a_wrap);
        reg_access(1'b1, 4'd0, 16'd1, 16'h0, a_cnt, a_wrap);
        n = 0;
        while (counter !== 15'd5 && n < 50) begin @(negedge sys_clk); n++; end
        chk("wait_cnt5", counter, 5);
        reg_access(1'b1, 4'd1, 16'd3, 16'h0, a_cnt, a_wrap);
        reg_access(1'b0, 4'd3, 16'h0, 16'h0003, a_cnt, a_wrap);
        begin
            logic [14:0] seq [10];
            seq = '{15'd9, 15'd0, 15'd1, 15'd2, 15'd3, 15'd0, 15'd1, 15'd2, 15'd3, 15'd0};
            for (int i = 0; i < 10; i++) begin
                cnt_q.push_back(seq[i]);
                wrap_q.push_back(i == 1 || i == 5 || i == 9);
            end
        end
        run_seq("shadow");
        reg_access(1'b0, 4'd3, 16'h0, 16'h0001, a_cnt, a_wrap);

        // clr on a wrap tick: counter 0, no tb_wrap
        n = 0;
        while (counter !== 15'd3 && n < 50) begin @(negedge sys_clk); n++; end
        chk("wait_cnt3", counter, 3);
        reg_access(1'b1, 4'd0, 16'd3, 16'h0, a_cnt, a_wrap);
        chk("clr_tick_cnt",  a_cnt, 0);
        chk("clr_tick_wrap", a_wrap, 0);
        chk("clr_after_cnt", counter, 1);

        // PERIOD=0: wrap on every tick
        reg_access(1'b1, 4'd0, 16'd2, 16'h0, a_cnt, a_wrap);
        reg_access(1'b1, 4'd1, 16'd0, 16'h0, a_cnt, a_wrap);
        reg_access(1'b1, 4'd0, 16'd1, 16'h0, a_cnt, a_wrap);
        for (int i = 0; i < 6; i++) begin
            cnt_q.push_back(15'd0);
            wrap_q.push_back(1'b1);
        end
        run_seq("p0");

        // Channel accesses
        ch_access(1'b1, 3'd1, 16'h0065, 16'hAAAA);
        ch_access(1'b0, 3'd0, 16'hFFFF, 16'h1234);
        ch_access(1'b0, 3'd3, 16'h0000, 16'hC0DE);

        // Unmapped addresses
        reg_access(1'b0, 4'd5,  16'h0, 16'h0000, a_cnt, a_wrap);
        reg_access(1'b1, 4'd13, 16'h5555, 16'h0, a_cnt, a_wrap);
        reg_access(1'b0, 4'd13, 16'h0, 16'h0000, a_cnt, a_wrap);

        // Reset in the middle of a channel access
        reg_access(1'b1, 4'd0, 16'd2, 16'h0, a_cnt, a_wrap);
        reg_access(1'b1, 4'd1, 16'd9, 16'h0, a_cnt, a_wrap);
        reg_access(1'b1, 4'd0, 16'd1, 16'h0, a_cnt, a_wrap);
        repeat (3) @(negedge sys_clk);
        hif.host_req   = 1'b1;
        hif.host_we    = 1'b1;
        hif.host_addr  = 4'd10;
        hif.host_wdata = 16'hBEEF;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_pre_cs",  ch_cs, 4'b0100);
        chk("rst_pre_cnt", (counter != 15'd0), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_cs",      ch_cs, 0);
        chk("rst_mid_oe",      ch_data_oe, 0);
        chk("rst_mid_do",      ch_data_o, 0);
        chk("rst_mid_counter", counter, 0);
        chk("rst_mid_ack",     hif.host_ack, 0);
        hif.host_req = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            chk($sformatf("rst_no_ack i%0d", i), hif.host_ack, 0);
        end
        reg_access(1'b0, 4'd1, 16'h0, 16'h7FFF, a_cnt, a_wrap);
        reg_access(1'b0, 4'd3, 16'h0, 16'h0000, a_cnt, a_wrap);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
